// File: rtl/vga_pkg.sv
// Shared timing defaults, coordinate widths and the per-axis phase type
// for the VGA raster generator.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACT/FP/SYNC/BP phase FSM.
// count/phase are look-ahead: the values the axis holds after the current edge.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FRONT  = 16,
    parameter int SYNC   = 96,
    parameter int BACK   = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output phase_t           phase,
    output logic             wrap
);

    localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
    localparam logic [CNT_W-1:0] LAST     = 10'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FP_AT    = 10'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_AT  = 10'(ACTIVE + FRONT);
    localparam logic [CNT_W-1:0] BP_AT    = 10'(ACTIVE + FRONT + SYNC);

    logic [CNT_W-1:0] cnt_q;
    phase_t           phase_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= PH_ACT;
        end else begin
            cnt_q   <= count;
            phase_q <= phase;
        end
    end

    assign wrap = en && (cnt_q == LAST);

    always_comb begin
        count = cnt_q;
        phase = phase_q;
        if (en) begin
            count = wrap ? '0 : cnt_q + 10'd1;
            // Phase changes on the same edge the counter enters the new region.
            case (phase_q)
                PH_ACT:  if (count == FP_AT)   phase = PH_FP;
                PH_FP:   if (count == SYNC_AT) phase = PH_SYNC;
                PH_SYNC: if (count == BP_AT)   phase = PH_BP;
                PH_BP:   if (wrap)             phase = PH_ACT;
                default: phase = PH_ACT;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, registered syncs/blank/x/y/strobes.
// Define VGA_FRAME_COUNT_EN to add the 8-bit frame_cnt output.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FRONT  = vga_pkg::H_FRONT,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BACK   = vga_pkg::H_BACK,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FRONT  = vga_pkg::V_FRONT,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BACK   = vga_pkg::V_BACK
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    pix_en,
    output logic [vga_pkg::X_W-1:0] x,
    output logic [vga_pkg::Y_W-1:0] y,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    blank,
    output logic                    line_start,
`ifdef VGA_FRAME_COUNT_EN
    output logic                    frame_start,
    output logic [7:0]              frame_cnt
`else
    output logic                    frame_start
`endif
);

    import vga_pkg::*;

    localparam logic [1:0]       DIV_LAST = 2'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_ACT_W  = 10'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_W  = 10'(V_ACTIVE);

    logic [1:0]       div_cnt;
    logic             tick;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    phase_t           h_phase;
    phase_t           v_phase;
    logic             h_wrap;
    logic             v_wrap;
    logic             blank_nxt;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= tick ? 2'd0 : div_cnt + 2'd1;
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h (
        .clk   (clk),
        .rst   (rst),
        .en    (tick),
        .count (h_cnt),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    // The vertical axis only moves when a line completes.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v (
        .clk   (clk),
        .rst   (rst),
        .en    (h_wrap),
        .count (v_cnt),
        .phase (v_phase),
        .wrap  (v_wrap)
    );

    assign blank_nxt = (h_cnt >= H_ACT_W) || (v_cnt >= V_ACT_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_en      <= 1'b0;
            x           <= '0;
            y           <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // Strobes are single-clk even when a pixel spans several clks.
            pix_en      <= tick;
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
            if (tick) begin
                hsync <= (h_phase != PH_SYNC);
                vsync <= (v_phase != PH_SYNC);
                blank <= blank_nxt;
                x     <= blank_nxt ? '0 : h_cnt;
                y     <= blank_nxt ? '0 : v_cnt[Y_W-1:0];
            end
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (h_wrap && v_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing vectors and sequences on one instance,
// randomized resets on two reduced-timing instances checked against an arithmetic raster model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pix_en;
        logic [9:0] x;
        logic [8:0] y;
        logic       hsync;
        logic       vsync;
        logic       blank;
        logic       line_start;
        logic       frame_start;
        logic [7:0] frame_cnt;
    } obs_t;

    typedef struct {
        int   n;
        obs_t exp;
    } vec_t;

    logic clk;
    logic rst_a;
    logic rst_s;
    logic chk_s;
    int   n_a;
    int   n_s;
    int   n_compared;
    int   n_mismatched;

    logic       pix_en_a, hsync_a, vsync_a, blank_a, ls_a, fs_a;
    logic [9:0] x_a;
    logic [8:0] y_a;
    logic [7:0] fc_a;
    logic       pix_en_b, hsync_b, vsync_b, blank_b, ls_b, fs_b;
    logic [9:0] x_b;
    logic [8:0] y_b;
    logic [7:0] fc_b;
    logic       pix_en_c, hsync_c, vsync_c, blank_c, ls_c, fs_c;
    logic [9:0] x_c;
    logic [8:0] y_c;
    logic [7:0] fc_c;

    obs_t got_a, got_b, got_c;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges seen since each reset was last released.
    always @(posedge clk or posedge rst_a) begin
        if (rst_a) n_a <= 0;
        else       n_a <= n_a + 1;
    end

    always @(posedge clk or posedge rst_s) begin
        if (rst_s) n_s <= 0;
        else       n_s <= n_s + 1;
    end

    // ---------------- DUTs ----------------
    vga_timing_gen #(.CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst_a), .pix_en(pix_en_a), .x(x_a), .y(y_a),
        .hsync(hsync_a), .vsync(vsync_a), .blank(blank_a),
        .line_start(ls_a),
`ifdef VGA_FRAME_COUNT_EN
        .frame_start(fs_a), .frame_cnt(fc_a)
`else
        .frame_start(fs_a)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) dut_b (
        .clk(clk), .rst(rst_s), .pix_en(pix_en_b), .x(x_b), .y(y_b),
        .hsync(hsync_b), .vsync(vsync_b), .blank(blank_b),
        .line_start(ls_b),
`ifdef VGA_FRAME_COUNT_EN
        .frame_start(fs_b), .frame_cnt(fc_b)
`else
        .frame_start(fs_b)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
        .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) dut_c (
        .clk(clk), .rst(rst_s), .pix_en(pix_en_c), .x(x_c), .y(y_c),
        .hsync(hsync_c), .vsync(vsync_c), .blank(blank_c),
        .line_start(ls_c),
`ifdef VGA_FRAME_COUNT_EN
        .frame_start(fs_c), .frame_cnt(fc_c)
`else
        .frame_start(fs_c)
`endif
    );

`ifndef VGA_FRAME_COUNT_EN
    assign fc_a = 8'd0;
    assign fc_b = 8'd0;
    assign fc_c = 8'd0;
`endif

    assign got_a = {pix_en_a, x_a, y_a, hsync_a, vsync_a, blank_a, ls_a, fs_a, fc_a};
    assign got_b = {pix_en_b, x_b, y_b, hsync_b, vsync_b, blank_b, ls_b, fs_b, fc_b};
    assign got_c = {pix_en_c, x_c, y_c, hsync_c, vsync_c, blank_c, ls_c, fs_c, fc_c};

    // ---------------- reference model ----------------
    // Position follows from the number of pixel ticks since reset release.
    function automatic obs_t model(input int n, input int d,
                                   input int ha, input int hf, input int hs, input int hb,
                                   input int va, input int vf, input int vs, input int vb);
        obs_t o;
        int ht, vt, k, p, h, v;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        k  = n / d;
        p  = k % (ht * vt);
        h  = p % ht;
        v  = p / ht;
        o.pix_en      = (n > 0) && (n % d == 0);
        o.blank       = (h >= ha) || (v >= va);
        o.x           = o.blank ? 10'd0 : 10'(h);
        o.y           = o.blank ? 9'd0 : 9'(v);
        o.hsync       = !((h >= ha + hf) && (h < ha + hf + hs));
        o.vsync       = !((v >= va + vf) && (v < va + vf + vs));
        o.line_start  = o.pix_en && (h == 0);
        o.frame_start = o.line_start && (v == 0);
`ifdef VGA_FRAME_COUNT_EN
        o.frame_cnt   = 8'((k / (ht * vt)) % 256);
`else
        o.frame_cnt   = 8'd0;
`endif
        return o;
    endfunction

    function automatic obs_t mk(input logic pe, input int xv, input int yv, input logic hs,
                                input logic vs, input logic bl, input logic ls, input logic fs);
        obs_t o;
        o = {pe, 10'(xv), 9'(yv), hs, vs, bl, ls, fs, 8'd0};
        return o;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s t=%0t got pix=%b x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b fc=%0d want pix=%b x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b fc=%0d",
                     name, $time, got.pix_en, got.x, got.y, got.hsync, got.vsync, got.blank,
                     got.line_start, got.frame_start, got.frame_cnt,
                     exp.pix_en, exp.x, exp.y, exp.hsync, exp.vsync, exp.blank,
                     exp.line_start, exp.frame_start, exp.frame_cnt);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_compared++;
        if (got != exp) begin
            n_mismatched++;
            $display("FAIL %s got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_compared++;
        n_mismatched++;
        $display("FAIL timeout_%s waited too long at t=%0t", name, $time);
    endtask

    always begin
        @(negedge clk);
        #1;
        if (chk_s) begin
            check("model_b", got_b, model(n_s, 1, 8, 1, 2, 1, 3, 1, 1, 1));
            check("model_c", got_c, model(n_s, 3, 16, 2, 3, 4, 6, 1, 2, 2));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_n_a(input int target, input string name);
        int guard;
        guard = 0;
        while (n_a < target && guard < 20000) begin
            step();
            guard++;
        end
        if (n_a != target) timeout(name);
    endtask

    task automatic run_a();
        vec_t vecs[15];
        int   low, t0, guard;
        vecs[0]  = '{0,    mk(0, 0,   0, 1, 1, 0, 0, 0)};
        vecs[1]  = '{1,    mk(0, 0,   0, 1, 1, 0, 0, 0)};
        vecs[2]  = '{2,    mk(1, 1,   0, 1, 1, 0, 0, 0)};
        vecs[3]  = '{3,    mk(0, 1,   0, 1, 1, 0, 0, 0)};
        vecs[4]  = '{4,    mk(1, 2,   0, 1, 1, 0, 0, 0)};
        vecs[5]  = '{1278, mk(1, 639, 0, 1, 1, 0, 0, 0)};
        vecs[6]  = '{1280, mk(1, 0,   0, 1, 1, 1, 0, 0)};
        vecs[7]  = '{1311, mk(0, 0,   0, 1, 1, 1, 0, 0)};
        vecs[8]  = '{1312, mk(1, 0,   0, 0, 1, 1, 0, 0)};
        vecs[9]  = '{1503, mk(0, 0,   0, 0, 1, 1, 0, 0)};
        vecs[10] = '{1504, mk(1, 0,   0, 1, 1, 1, 0, 0)};
        vecs[11] = '{1599, mk(0, 0,   0, 1, 1, 1, 0, 0)};
        vecs[12] = '{1600, mk(1, 0,   1, 1, 1, 0, 1, 0)};
        vecs[13] = '{1601, mk(0, 0,   1, 1, 1, 0, 0, 0)};
        vecs[14] = '{1602, mk(1, 1,   1, 1, 1, 0, 0, 0)};

        rst_a = 1'b0;
        #1;
        for (int i = 0; i < 15; i++) begin
            wait_n_a(vecs[i].n, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_n%0d", i, vecs[i].n), got_a, vecs[i].exp);
        end

        // hsync low width on line 1
        guard = 0;
        while (hsync_a !== 1'b0 && guard < 4000) begin step(); guard++; end
        if (hsync_a !== 1'b0) timeout("hsync_fall");
        check_int("hsync_fall_at_clk", n_a, 2912);
        low = 0;
        while (hsync_a === 1'b0 && low < 1000) begin low++; step(); end
        check_int("hsync_low_clks", low, 192);

        // line_start spacing
        guard = 0;
        while (ls_a !== 1'b1 && guard < 4000) begin step(); guard++; end
        if (ls_a !== 1'b1) timeout("line_start_1");
        t0 = n_a;
        step();
        guard = 0;
        while (ls_a !== 1'b1 && guard < 4000) begin step(); guard++; end
        if (ls_a !== 1'b1) timeout("line_start_2");
        check_int("line_start_period", n_a - t0, 1600);

        // reset mid-frame at line 3, h=400
        wait_n_a(5600, "midframe");
        check("pos_line3_h400", got_a, mk(1, 400, 3, 1, 1, 0, 0, 0));
        rst_a = 1'b1;
        #1;
        check("async_reset_values", got_a, mk(0, 0, 0, 1, 1, 0, 0, 0));
        repeat (3) @(negedge clk);
        check("held_reset_values", got_a, mk(0, 0, 0, 1, 1, 0, 0, 0));
        rst_a = 1'b0;
        guard = 0;
        while (hsync_a !== 1'b0 && guard < 4000) begin step(); guard++; end
        if (hsync_a !== 1'b0) timeout("hsync_after_reset");
        check_int("hsync_fall_after_reset", n_a, 1312);
    endtask

    task automatic run_s();
        int t0, guard;
        repeat (6) begin
            repeat ($urandom_range(150, 900)) @(negedge clk);
            rst_s = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_s = 1'b0;
        end
        // clean stretch long enough for the frame counter of dut_b to wrap
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        guard = 0;
        #1;
        while (fs_b !== 1'b1 && guard < 500) begin step(); guard++; end
        if (fs_b !== 1'b1) timeout("frame_start_b_1");
        t0 = n_s;
        step();
        guard = 0;
        while (fs_b !== 1'b1 && guard < 500) begin step(); guard++; end
        if (fs_b !== 1'b1) timeout("frame_start_b_2");
        check_int("frame_start_period_b", n_s - t0, 72);
        while (n_s < 258 * 72 + 5) step();
    endtask

    // ---------------- main ----------------
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        chk_s = 1'b0;
        rst_a = 1'b1;
        rst_s = 1'b1;
        repeat (3) @(negedge clk);
        chk_s = 1'b1;
        rst_s = 1'b0;
        fork
            run_a();
            run_s();
        join
        chk_s = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
